// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the RV32I multicycle control FSM.
//   state_e        : FSM state encoding
//   OPC_*          : 7-bit major opcodes (ir[6:0]) the core accepts
//   wb_sel_e       : register-file writeback source select
//   trap_cause_e   : cause code reported alongside the sticky trap flag
//   instr_class_e  : coarse instruction class produced by rv_opcode_decode
//   is_mem_class() : true for classes that need a data-bus access
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_BUS_TMO = 2'd2
    } trap_cause_e;

    // LUI, AUIPC, OP and OP-IMM all behave identically from the control
    // point of view (ALU result written back, PC += 4), so they share a class.
    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_JAL    = 3'd1,
        CLS_JALR   = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_LOAD   = 3'd4,
        CLS_STORE  = 3'd5
    } instr_class_e;

    // Width of the bus-timeout counter; covers MEM_TIMEOUT up to 65535.
    localparam int TMO_W = 16;

    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// ---------------------------------------------------------------------------
// rv_opcode_decode
// Combinational classifier for the latched instruction word.
// Only the major opcode field is needed to pick the control sequence, so the
// block takes ir[6:0] rather than the whole word.
//   opcode  in  7  ir[6:0]
//   cls     out    instruction class (valid when illegal=0)
//   illegal out 1  instruction is not a supported RV32I major opcode
// ---------------------------------------------------------------------------
module rv_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls,
    output logic         illegal
);

    always_comb begin
        cls     = CLS_ALU;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI,
            OPC_AUIPC,
            OPC_OP_IMM,
            OPC_OP:     cls = CLS_ALU;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            default:    illegal = 1'b1;
        endcase
        // Compressed / non-32-bit encodings are rejected outright. Every
        // listed opcode already ends in 2'b11; this keeps the rule explicit
        // if the opcode list ever grows.
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// core_ctrl_fsm
// Multicycle control sequencer for the RV32I core:
//   BOOT -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WB -> FETCH ...
// with a sticky TRAP state for illegal instructions and bus timeouts.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   imem_rdata/ack     instruction bus read data and acknowledge
//   imem_req           instruction fetch request (held until ack)
//   ir                 latched instruction register
//   dmem_ack           data bus acknowledge
//   dmem_req/we        data access request (held until ack), 1=store
//   branch_taken       ALU compare result, sampled during WB
//   inc_pc             one-cycle PC increment strobe
//   sel_addr           one-cycle PC load strobe (JALR target)
//   incr_imm           PC increment source: 1=immediate, 0=4
//   rf_we              one-cycle register-file write enable
//   wb_sel             writeback source (wb_sel_e)
//   trap, trap_cause   sticky fault flag and its cause (trap_cause_e)
//
// Outputs are a Moore decode of the state register (plus ir, and
// branch_taken for the branch increment source), so every request and strobe
// drops the moment reset_n falls.
// ---------------------------------------------------------------------------
module core_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] ir,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        branch_taken,
    output logic        inc_pc,
    output logic        sel_addr,
    output logic        incr_imm,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    // The counter holds the number of request cycles already spent without
    // ack; the cycle in which it equals MEM_TIMEOUT-1 is the last one allowed.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e           state;
    logic [TMO_W-1:0] tmo_cnt;
    trap_cause_e      cause_q;
    instr_class_e     cls;
    logic             illegal;
    logic             tmo_hit;

    rv_opcode_decode u_dec (
        .opcode  (ir[6:0]),
        .cls     (cls),
        .illegal (illegal)
    );

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // -----------------------------------------------------------------------
    // State, instruction register, timeout counter and trap cause.
    // Acks are only consulted in the state that owns the matching request,
    // so stray acks elsewhere fall through untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_BOOT;
            ir      <= '0;
            tmo_cnt <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state)
                ST_BOOT: begin
                    state   <= ST_FETCH;
                    tmo_cnt <= '0;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_DECODE;
                    end else if (tmo_hit) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_BUS_TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (illegal) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem_class(cls)) begin
                        state   <= ST_MEM;
                        tmo_cnt <= '0;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // Ack in the final allowed cycle takes priority over the
                    // timeout.
                    if (dmem_ack) begin
                        state <= ST_WB;
                    end else if (tmo_hit) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_BUS_TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    state   <= ST_FETCH;
                    tmo_cnt <= '0;
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode. All PC/RF strobes live in WB only, so each fires
    // exactly once per retired instruction; JALR is the only class that
    // loads the PC, and it never increments it.
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req   = (state == ST_FETCH);
        dmem_req   = (state == ST_MEM);
        dmem_we    = (state == ST_MEM) && (cls == CLS_STORE);
        inc_pc     = 1'b0;
        sel_addr   = 1'b0;
        incr_imm   = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        trap       = (state == ST_TRAP);
        trap_cause = cause_q;
        if (state == ST_WB) begin
            case (cls)
                CLS_JAL: begin
                    inc_pc   = 1'b1;
                    incr_imm = 1'b1;
                    rf_we    = 1'b1;
                    wb_sel   = WB_PC4;
                end
                CLS_JALR: begin
                    sel_addr = 1'b1;
                    rf_we    = 1'b1;
                    wb_sel   = WB_PC4;
                end
                CLS_BRANCH: begin
                    inc_pc   = 1'b1;
                    incr_imm = branch_taken;
                end
                CLS_LOAD: begin
                    inc_pc = 1'b1;
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                end
                CLS_STORE: begin
                    inc_pc = 1'b1;
                end
                default: begin
                    inc_pc = 1'b1;
                    rf_we  = 1'b1;
                    wb_sel = WB_ALU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl_fsm
// Scoreboard bench: the driver plays both buses, and for every instruction it
// issues pushes the expected writeback / data request / trap event (with the
// cycle it must appear in) computed from the instruction-class rules. A
// separate monitor pops and compares whenever the DUT shows one of those
// events.
// ---------------------------------------------------------------------------
module tb_core_ctrl_fsm;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] ir;
    logic        dmem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        branch_taken = 1'b0;
    logic        inc_pc;
    logic        sel_addr;
    logic        incr_imm;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  trap_cause;

    always #5 clk = ~clk;

    core_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .ir           (ir),
        .dmem_ack     (dmem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .branch_taken (branch_taken),
        .inc_pc       (inc_pc),
        .sel_addr     (sel_addr),
        .incr_imm     (incr_imm),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       legal, mem, we, inc_pc, sel_addr, incr_imm, is_br, rf_we;
        bit [1:0] wb_sel;
    } ref_t;

    typedef struct { ref_t r; int cyc; }           wb_exp_t;
    typedef struct { bit we; int cyc; }            mem_exp_t;
    typedef struct { bit [1:0] cause; int cyc; }   trap_exp_t;

    wb_exp_t   wb_q[$];
    mem_exp_t  mem_q[$];
    trap_exp_t trap_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int next_fetch = 0;
    bit have_next  = 0;
    int bt_mode    = 2;   // 0: branch_taken=0, 1: =1, else random per cycle

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endfunction

    // What the control unit must do in WB for a given instruction word.
    function automatic ref_t ref_model(input logic [31:0] instr);
        ref_t r;
        r = '{default: 0};
        r.legal = 1;
        case (instr[6:0])
            7'h37, 7'h17, 7'h13, 7'h33: begin r.inc_pc = 1; r.rf_we = 1; r.wb_sel = 0; end
            7'h6F: begin r.inc_pc = 1; r.incr_imm = 1; r.rf_we = 1; r.wb_sel = 2; end
            7'h67: begin r.sel_addr = 1; r.rf_we = 1; r.wb_sel = 2; end
            7'h63: begin r.inc_pc = 1; r.is_br = 1; end
            7'h03: begin r.mem = 1; r.inc_pc = 1; r.rf_we = 1; r.wb_sel = 1; end
            7'h23: begin r.mem = 1; r.we = 1; r.inc_pc = 1; end
            default: r.legal = 0;
        endcase
        return r;
    endfunction

    function automatic void push_wb(input ref_t r, input int c);
        wb_exp_t e;
        e.r = r; e.cyc = c;
        wb_q.push_back(e);
    endfunction

    function automatic void push_mem(input bit we, input int c);
        mem_exp_t e;
        e.we = we; e.cyc = c;
        mem_q.push_back(e);
    endfunction

    function automatic void push_trap(input bit [1:0] cause, input int c);
        trap_exp_t e;
        e.cause = cause; e.cyc = c;
        trap_q.push_back(e);
    endfunction

    // ---------------- branch_taken driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (bt_mode)
                0:       branch_taken = 1'b0;
                1:       branch_taken = 1'b1;
                default: branch_taken = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        wb_exp_t   we_e;
        mem_exp_t  me_e;
        trap_exp_t te_e;
        logic      pd, pt;
        pd = 0; pt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pd = 0; pt = 0;
            end else begin
                if (inc_pc || sel_addr || rf_we) begin
                    if (wb_q.size() == 0) chk("unexpected_wb", 1, 0);
                    else begin
                        we_e = wb_q.pop_front();
                        chk("wb_cycle", cyc, we_e.cyc);
                        chk("wb_inc_pc", inc_pc, we_e.r.inc_pc);
                        chk("wb_sel_addr", sel_addr, we_e.r.sel_addr);
                        chk("wb_incr_imm", incr_imm, we_e.r.is_br ? branch_taken : we_e.r.incr_imm);
                        chk("wb_rf_we", rf_we, we_e.r.rf_we);
                        if (we_e.r.rf_we) chk("wb_sel", wb_sel, we_e.r.wb_sel);
                    end
                end
                if (dmem_req && !pd) begin
                    if (mem_q.size() == 0) chk("unexpected_dmem_req", 1, 0);
                    else begin
                        me_e = mem_q.pop_front();
                        chk("dmem_req_cycle", cyc, me_e.cyc);
                        chk("dmem_we", dmem_we, me_e.we);
                    end
                end
                if (trap && !pt) begin
                    if (trap_q.size() == 0) chk("unexpected_trap", 1, 0);
                    else begin
                        te_e = trap_q.pop_front();
                        chk("trap_cycle", cyc, te_e.cyc);
                        chk("trap_cause", trap_cause, te_e.cause);
                    end
                end
                if (trap)
                    chk("trap_quiet", {imem_req, dmem_req, dmem_we, inc_pc, sel_addr,
                                       incr_imm, rf_we, wb_sel}, 0);
                pd = dmem_req;
                pt = trap;
            end
        end
    end

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic wait_sig(input bit imem, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem ? imem_req : dmem_req) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, inc_pc, sel_addr, incr_imm,
                            rf_we, wb_sel, trap, trap_cause}, 0);
        chk("rst_ir", ir, 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("trap_q_drained", trap_q.size(), 0);
        wb_q.delete(); mem_q.delete(); trap_q.delete();
        imem_ack = 0; dmem_ack = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("boot_no_req", imem_req, 0);
        next_fetch = cyc + 1;
        have_next  = 1;
    endtask

    // dm: data-ack delay in cycles; -1 never acks, -2 resets mid-MEM.
    task automatic run_instr(input logic [31:0] instr, input int di, input int dm);
        ref_t r;
        bit   ok;
        int   a, rc;
        r = ref_model(instr);
        wait_sig(1, ok);
        if (!ok) begin chk("imem_req_seen", 0, 1); return; end
        if (have_next) chk("fetch_cycle", cyc, next_fetch);
        have_next = 0;
        for (int i = 0; i < di; i++) begin
            dmem_ack = 1'($urandom_range(0, 1));   // must be ignored in FETCH
            @(negedge clk);
        end
        dmem_ack = 0; imem_ack = 1; imem_rdata = instr;
        a = cyc + 1;
        if (!r.legal)    push_trap(2'd1, a + 1);
        else if (r.mem)  push_mem(r.we, a + 2);
        else             push_wb(r, a + 2);
        @(negedge clk);
        imem_ack = 0; imem_rdata = $urandom;
        if (!r.legal) return;
        if (!r.mem) begin next_fetch = a + 3; have_next = 1; return; end
        wait_sig(0, ok);
        if (!ok) begin chk("dmem_req_seen", 0, 1); return; end
        rc = cyc;
        if (dm == -2) begin
            chk("mem_req_before_rst", dmem_req, 1);
            do_reset();
            return;
        end
        if (dm == -1) begin
            push_trap(2'd2, rc + TMO);
            for (int i = 0; i < TMO + 2; i++) begin
                imem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            imem_ack = 0;
            return;
        end
        for (int i = 0; i < dm; i++) begin
            imem_ack = 1'($urandom_range(0, 1));   // must be ignored in MEM
            imem_rdata = $urandom;
            @(negedge clk);
        end
        imem_ack = 0; dmem_ack = 1;
        push_wb(r, cyc + 1);
        next_fetch = cyc + 2; have_next = 1;
        @(negedge clk);
        dmem_ack = 0;
    endtask

    task automatic fetch_timeout();
        bit ok;
        wait_sig(1, ok);
        if (!ok) begin chk("imem_req_seen", 0, 1); return; end
        if (have_next) chk("fetch_cycle", cyc, next_fetch);
        have_next = 0;
        push_trap(2'd2, cyc + TMO);
        for (int i = 0; i < TMO + 2; i++) begin
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        dmem_ack = 0;
    endtask

    // ---------------- main sequence ----------------
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    initial begin
        logic [31:0] rnd;
        do_reset();

        run_instr(32'h00500093, 0, 0);   // ADDI x1,x0,5
        run_instr(32'h008000EF, 0, 0);   // JAL
        run_instr(32'h00008067, 0, 0);   // JALR
        bt_mode = 1;
        run_instr(32'h00000463, 0, 0);   // BEQ taken
        bt_mode = 0;
        run_instr(32'h00000463, 0, 0);   // BEQ not taken
        bt_mode = 2;
        run_instr(32'h00002083, 0, 3);   // LW, ack in the last allowed cycle
        run_instr(32'h00102023, 0, 0);   // SW

        for (int n = 0; n < 150; n++) begin
            rnd = $urandom;
            run_instr({rnd[31:7], ops[$urandom_range(0, 8)]},
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run_instr(32'h00002083, 0, -1);  // LW, dmem never acks
        do_reset();
        run_instr(32'hFFFFFFFF, 1, 0);
        repeat (4) @(negedge clk);
        do_reset();
        run_instr(32'h00000000, 0, 0);
        repeat (4) @(negedge clk);
        do_reset();
        fetch_timeout();
        do_reset();
        run_instr(32'h00002083, 1, -2);  // reset while dmem_req is high
        run_instr(32'h00500093, 2, 0);
        repeat (3) @(negedge clk);

        chk("end_wb_q_empty", wb_q.size(), 0);
        chk("end_mem_q_empty", mem_q.size(), 0);
        chk("end_trap_q_empty", trap_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multicycle control FSM for the RV32I core. It sequences the program counter, instruction fetch, data-memory access and register-file writeback. It drives the PC's increment/load strobes and selects the PC increment source (+4 or immediate). It sits between the instruction/data bus interfaces and the datapath (PC, ALU, register file).

Parameters:
MEM_TIMEOUT, 255, max cycles a bus request may wait for ack before a bus-timeout trap (1..65535)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
imem_rdata  in  32  instruction word, valid when imem_ack=1
imem_ack  in  1  instruction bus acknowledge
imem_req  out  1  instruction fetch request, held until ack
ir  out  32  latched instruction register
dmem_ack  in  1  data bus acknowledge
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  1=store, 0=load; valid with dmem_req
branch_taken  in  1  ALU compare result for current branch
inc_pc  out  1  one-cycle PC increment strobe
sel_addr  out  1  one-cycle PC load strobe (JALR target)
incr_imm  out  1  PC increment source: 1=immediate, 0=constant 4
rf_we  out  1  one-cycle register-file write enable
wb_sel  out  2  writeback source: 0=ALU, 1=MEM, 2=PC+4
trap  out  1  sticky fault flag
trap_cause  out  2  0=none, 1=illegal instruction, 2=bus timeout

Behaviour:
- States: BOOT, FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Moore outputs are decoded from the state register and ir.
- Reset state is BOOT; all outputs are 0 and ir=0. BOOT->FETCH unconditionally after one cycle, so no request is asserted during reset or in the first cycle after it.
- FETCH: imem_req=1. On imem_ack, ir<=imem_rdata, ->DECODE. Zero-wait ack (ack in the first FETCH cycle) is legal.
- DECODE (1 cycle):
  - Illegal if ir[1:0]!=2'b11 or opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Illegal ->TRAP with cause 1. Otherwise ->EXECUTE.
- EXECUTE (1 cycle): LOAD/STORE ->MEM; all others ->WB.
- MEM: dmem_req=1, dmem_we=1 for STORE. On dmem_ack ->WB.
- WB (1 cycle), strobes asserted exactly once per instruction:
  - JAL: inc_pc=1, incr_imm=1, rf_we=1, wb_sel=2.
  - JALR: sel_addr=1, inc_pc=0, rf_we=1, wb_sel=2.
  - BRANCH: inc_pc=1, incr_imm=branch_taken, rf_we=0. branch_taken is sampled in WB.
  - LOAD: inc_pc=1, incr_imm=0, rf_we=1, wb_sel=1.
  - STORE: inc_pc=1, incr_imm=0, rf_we=0.
  - LUI, AUIPC, OP, OP-IMM: inc_pc=1, incr_imm=0, rf_we=1, wb_sel=0.
  - Then ->FETCH.
- sel_addr and inc_pc are never both 1.
- Outside WB: inc_pc, sel_addr, rf_we are 0; incr_imm and wb_sel are 0.
- Latency with zero-wait ack: 4 cycles for non-memory instructions, 5 for LOAD/STORE.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the request is high without ack.
  - Reaching MEM_TIMEOUT without ack ->TRAP with cause 2.
  - Ack in the same cycle the count reaches MEM_TIMEOUT wins: no trap.
- An ack received while the matching request is low is ignored. imem_ack in MEM and dmem_ack in FETCH are ignored.
- TRAP: trap=1, trap_cause held, all requests and strobes 0. Exit only via reset.
- Reset mid-operation (any state, including with a request pending) returns to BOOT immediately. Requests drop asynchronously.

Decomposition:
- Package ctrl_pkg: state enum, opcode localparams (7-bit), wb_sel enum, trap-cause enum.
- Sub-module rv_opcode_decode: combinational; ir -> instruction class enum plus illegal flag.
- core_ctrl_fsm instantiates rv_opcode_decode and holds the state, ir and timeout counter.

Test Plan:
- ADDI x1,x0,5 (0x00500093), zero-wait imem_ack -> BOOT, then inc_pc=1, incr_imm=0, rf_we=1, wb_sel=0 in WB, 4 cycles per instruction, imem_req again in the next cycle.
- JAL (0x008000EF) -> WB: inc_pc=1, incr_imm=1, rf_we=1, wb_sel=2. JALR (0x00008067) -> sel_addr=1, inc_pc=0.
- BEQ (0x00000463) with branch_taken=1, then with 0 -> incr_imm=1, then 0. rf_we=0 both times.
- LW with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles with dmem_we=0, then WB rf_we=1, wb_sel=1. SW -> dmem_we=1, rf_we=0.
- imem_rdata=0xFFFFFFFF, then a separate run with imem_rdata=0x00000000 -> each run ends in TRAP with trap_cause=1, all strobes 0 thereafter. MEM_TIMEOUT=4 with dmem_ack never asserted -> TRAP with cause 2 after 4 cycles in MEM.
- reset_n pulsed low while in MEM with dmem_req=1 -> dmem_req=0 immediately, state BOOT, ir=0, trap cleared.
